// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and
// load/store traffic. One transaction at a time, alternating priority when
// both sides request, with a bounded wait for mem_ready.
module mem_arbiter #(
    parameter int n       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [n-1:0] if_addr,
    output logic         if_ack,
    output logic [n-1:0] if_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic         d_ack,
    output logic [n-1:0] d_rdata,
    output logic         err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic         stall
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Last BUSY cycle allowed before giving up on mem_ready.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic         owner_d_q, owner_d_d;    // 1 = data side owns the transaction
    logic         last_d_q, last_d_d;      // 1 = previous grant went to data
    logic         we_q, we_d;
    logic [n-1:0] addr_q, addr_d;
    logic [n-1:0] wdata_q, wdata_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic [n-1:0] if_rdata_q, if_rdata_d;
    logic [n-1:0] d_rdata_q, d_rdata_d;
    logic         grant_d;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_d_q  <= 1'b0;
            last_d_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_d_q  <= owner_d_d;
            last_d_q   <= last_d_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state: arbitrate in IDLE, wait for mem_ready or timeout in BUSY,
    // spend a single cycle in RESP to deliver the ack.
    always_comb begin
        state_d    = state_q;
        owner_d_d  = owner_d_q;
        last_d_d   = last_d_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        // Data wins unless fetch is also waiting and data had the last turn.
        grant_d    = d_req & (~if_req | ~last_d_q);
        case (state_q)
            IDLE: begin
                if (if_req | d_req) begin
                    owner_d_d = grant_d;
                    last_d_d  = grant_d;
                    addr_d    = grant_d ? d_addr : if_addr;
                    we_d      = grant_d & d_we;
                    wdata_d   = grant_d ? d_wdata : '0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ready) begin
                    // A ready in the final allowed cycle still counts as success.
                    if (!owner_d_q)  if_rdata_d = mem_rdata;
                    else if (!we_q)  d_rdata_d  = mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // Stores never disturb d_rdata, even on timeout.
                    if (!owner_d_q)  if_rdata_d = '0;
                    else if (!we_q)  d_rdata_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from state; memory side is quiet outside BUSY.
    always_comb begin
        mem_req   = (state_q == BUSY);
        mem_we    = mem_req & we_q;
        mem_addr  = mem_req ? addr_q  : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        if_ack    = (state_q == RESP) & ~owner_d_q;
        d_ack     = (state_q == RESP) &  owner_d_q;
        err       = (state_q == RESP) &  err_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        stall     = (if_req & ~if_ack) | (d_req & ~d_ack);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of grants, latency and data.
module tb_mem_arbiter;
    localparam int N  = 32;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req, d_req, d_we, mem_ready;
    logic [N-1:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic         if_ack, d_ack, err, mem_req, mem_we, stall;
    logic [N-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    mem_arbiter #(.n(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: who had the last grant and what each rdata should hold.
    bit           m_last_d = 1'b0;
    logic [N-1:0] m_if_rd  = '0;
    logic [N-1:0] m_d_rd   = '0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Nothing in flight: memory quiet, no acks, rdata holding.
    task automatic check_quiet(input string tag);
        chk({tag, "_mem_req"}, N'(mem_req), 0);
        chk({tag, "_mem_we"}, N'(mem_we), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_ack"}, N'(if_ack), 0);
        chk({tag, "_d_ack"}, N'(d_ack), 0);
        chk({tag, "_err"}, N'(err), 0);
        chk({tag, "_if_rdata"}, if_rdata, m_if_rd);
        chk({tag, "_d_rdata"}, d_rdata, m_d_rd);
        chk({tag, "_stall"}, N'(stall), N'(if_req | d_req));
    endtask

    // One full transaction. Called #1 after a rising edge with the arbiter in
    // IDLE and at least one request raised. lat = BUSY cycle in which
    // mem_ready is given (lat > TO means never). Returns the granted side.
    task automatic txn(input int lat, input logic [N-1:0] rd, output bit gd);
        bit           timeout, ewe;
        int           nb;
        logic [N-1:0] ea, ew;
        gd      = (if_req && d_req) ? !m_last_d : d_req;
        ea      = gd ? d_addr : if_addr;
        ewe     = gd && d_we;
        ew      = gd ? d_wdata : '0;
        timeout = (lat > TO);
        nb      = timeout ? TO : lat;
        @(negedge clk);
        check_quiet("idle");
        @(posedge clk); #1;
        for (int k = 1; k <= nb; k++) begin
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? rd : N'($urandom());
            @(negedge clk);
            chk("busy_mem_req", N'(mem_req), 1);
            chk("busy_mem_addr", mem_addr, ea);
            chk("busy_mem_we", N'(mem_we), N'(ewe));
            chk("busy_mem_wdata", mem_wdata, ew);
            chk("busy_acks", N'({if_ack, d_ack, err}), 0);
            chk("busy_stall", N'(stall), 1);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        if (!gd)       m_if_rd = timeout ? '0 : rd;
        else if (!ewe) m_d_rd  = timeout ? '0 : rd;
        @(negedge clk);
        chk("resp_if_ack", N'(if_ack), N'(!gd));
        chk("resp_d_ack", N'(d_ack), N'(gd));
        chk("resp_err", N'(err), N'(timeout));
        chk("resp_mem_req", N'(mem_req), 0);
        chk("resp_mem_we", N'(mem_we), 0);
        chk("resp_mem_wdata", mem_wdata, 0);
        chk("resp_if_rdata", if_rdata, m_if_rd);
        chk("resp_d_rdata", d_rdata, m_d_rd);
        chk("resp_stall", N'(stall), N'(gd ? if_req : d_req));
        m_last_d = gd;
        @(posedge clk); #1;
    endtask

    initial begin
        bit gd;
        rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        chk("reset_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Both sides held: data first out of reset, then strict alternation
        if_req = 1; if_addr = 32'h0000_0400;
        d_req = 1; d_we = 0; d_addr = 32'h0000_3000;
        for (int k = 0; k < 4; k++) begin
            txn(1, N'($urandom()), gd);
            chk("alternate", N'(gd), N'(k % 2 == 0));
        end
        if_req = 0; d_req = 0;

        // Fetch only, single-cycle memory
        if_req = 1; if_addr = 32'h0000_0100;
        txn(1, 32'h0050_0093, gd);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
        if_req = 0;

        // Store with ready on the third BUSY cycle; d_rdata must not move
        d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        txn(3, 32'h1234_5678, gd);
        d_req = 0; d_we = 0;

        // Load timeout, then a fetch that completes cleanly
        d_req = 1; d_addr = 32'h0000_2004;
        txn(TO + 3, 32'h5555_AAAA, gd);
        chk("timeout_d_rdata", d_rdata, 0);
        d_req = 0;
        if_req = 1; if_addr = 32'h0000_0104;
        txn(2, 32'h00A0_0113, gd);
        if_req = 0;

        // mem_ready in the last allowed cycle beats the timeout
        d_req = 1; d_addr = 32'h0000_2008;
        txn(TO, 32'hCAFE_F00D, gd);
        d_req = 0;

        // Reset in the second BUSY cycle abandons the load
        d_req = 1; d_we = 0; d_addr = 32'h0000_200C;
        @(negedge clk);
        check_quiet("pre_rst_idle");
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_busy1_mem_req", N'(mem_req), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy2_mem_req", N'(mem_req), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        m_last_d = 1'b0; m_if_rd = '0; m_d_rd = '0;
        if_req = 1; if_addr = 32'h0000_0108;
        chk("post_rst_mem_addr", mem_addr, 0);
        chk("post_rst_mem_req", N'(mem_req), 0);
        chk("post_rst_acks", N'({if_ack, d_ack, err}), 0);
        txn(1, 32'h0BAD_C0DE, gd);
        chk("post_rst_data_first", N'(gd), 1);
        if_req = 0; d_req = 0;

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            if (!if_req && !d_req) begin
                @(negedge clk);
                check_quiet("gap");
                @(posedge clk); #1;
                case ($urandom_range(1, 3))
                    1: begin if_req = 1; if_addr = N'($urandom()); end
                    2: begin d_req = 1; d_we = 1'($urandom()); d_addr = N'($urandom()); d_wdata = N'($urandom()); end
                    default: begin
                        if_req = 1; if_addr = N'($urandom());
                        d_req = 1; d_we = 1'($urandom()); d_addr = N'($urandom()); d_wdata = N'($urandom());
                    end
                endcase
            end
            txn($urandom_range(1, TO + 2), N'($urandom()), gd);
            if (gd) begin
                d_req = 1'($urandom()); d_we = 1'($urandom());
                d_addr = N'($urandom()); d_wdata = N'($urandom());
            end else begin
                if_req = 1'($urandom()); if_addr = N'($urandom());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
